// File: rtl/pix_pkg.sv
// Shared types and scan-extent helpers for the pixel streaming path.
// Build option: define ZERO_PAD_EN to scan a one-pixel zero border around the frame.
package pix_pkg;

  localparam int unsigned PIX_W = 8;

`ifdef ZERO_PAD_EN
  localparam int unsigned PAD = 2;
`else
  localparam int unsigned PAD = 0;
`endif

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  function automatic int unsigned scan_w(input int unsigned width);
    return width + PAD;
  endfunction

  function automatic int unsigned scan_h(input int unsigned height);
    return height + PAD;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter with enable and end-of-line/frame flags.
module raster_counter
  import pix_pkg::*;
#(
  parameter int unsigned COLS  = 4,
  parameter int unsigned ROWS  = 3,
  parameter int unsigned COL_W = cnt_w(COLS),
  parameter int unsigned ROW_W = cnt_w(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_col,
  output logic             last_row,
  output logic             last_pos
);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  assign col      = col_q;
  assign row      = row_q;
  assign last_col = (col_q == COL_W'(COLS - 1));
  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign last_pos = last_col && last_row;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (en) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_frame_reader.sv
// Reads one frame from a synchronous-read RAM and streams it with sof/eol/eof markers.
// Build option: ZERO_PAD_EN adds a zero border ring that is emitted without RAM reads.
module pixel_frame_reader
  import pix_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              valid_out,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SCAN_W = scan_w(WIDTH);
  localparam int unsigned SCAN_H = scan_h(HEIGHT);
  localparam int unsigned COL_W  = cnt_w(SCAN_W);
  localparam int unsigned ROW_W  = cnt_w(SCAN_H);

  state_e state_q, state_d;

  logic             start_acc, issue, pad, rd_en;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_col, last_row, last_pos;

  logic [ADDR_W-1:0] addr_q;
  logic              valid_q, pad_q, sof_q, eol_q, eof_q, done_q;

  assign start_acc = (state_q == StIdle) && start;
  assign issue     = (state_q == StRun) && !hold;

`ifdef ZERO_PAD_EN
  assign pad = (col == '0) || last_col || (row == '0) || last_row;
`else
  assign pad = 1'b0;
`endif

  assign rd_en = issue && !pad;

  raster_counter #(
    .COLS (SCAN_W),
    .ROWS (SCAN_H),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_acc),
    .en      (issue),
    .col     (col),
    .row     (row),
    .last_col(last_col),
    .last_row(last_row),
    .last_pos(last_pos)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (issue && last_pos) state_d = StDrain;
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      valid_q <= 1'b0;
      pad_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        addr_q <= '0;
      end else if (rd_en) begin
        addr_q <= addr_q + 1'b1;
      end
      // Markers travel with the read so they line up with the RAM data next cycle.
      valid_q <= issue;
      pad_q   <= issue && pad;
      sof_q   <= issue && (col == '0) && (row == '0);
      eol_q   <= issue && last_col;
      eof_q   <= issue && last_col && last_row;
      done_q  <= (state_q == StDrain);
    end
  end

  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;
  assign pixel_out = (valid_q && !pad_q) ? mem_rdata : '0;
  assign valid_out = valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_frame_reader.sv
// Self-checking bench for pixel_frame_reader: scenario table plus reset and back-to-back sequences.
module tb_pixel_frame_reader;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned HEIGHT = 3;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PIX_W  = 8;
`ifdef ZERO_PAD_EN
  localparam bit          ZP = 1'b1;
  localparam int unsigned SW = WIDTH + 2;
  localparam int unsigned SH = HEIGHT + 2;
`else
  localparam bit          ZP = 1'b0;
  localparam int unsigned SW = WIDTH;
  localparam int unsigned SH = HEIGHT;
`endif
  localparam int NPOS = int'(SW * SH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata = '0;
  logic [PIX_W-1:0]  pixel_out;
  logic              valid_out, sof, eol, eof, busy, done;

  always #5 clk = ~clk;

  pixel_frame_reader #(
    .PIX_W (PIX_W),
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hold     (hold),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .pixel_out(pixel_out),
    .valid_out(valid_out),
    .sof      (sof),
    .eol      (eol),
    .eof      (eof),
    .busy     (busy),
    .done     (done)
  );

  // Frame RAM model: RAM[a] = a + 16, one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= 8'(mem_addr) + 8'd16;
  end

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
    logic       pad;
  } exp_t;

  typedef struct {
    int hold_after;
    int hold_len;
    int restart_mid;
    bit restart_drain;
    int exp_k;
  } scen_t;

  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                pix_cnt = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              prev_rd_en = 1'b0;
  scen_t             tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    int idx = 0;
    for (int r = 0; r < int'(SH); r++) begin
      for (int c = 0; c < int'(SW); c++) begin
        exp_t e;
        e.pad = ZP && (r == 0 || r == int'(SH) - 1 || c == 0 || c == int'(SW) - 1);
        e.pix = e.pad ? 8'd0 : 8'(idx + 16);
        if (!e.pad) idx++;
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == int'(SW) - 1);
        e.eof = e.eol && (r == int'(SH) - 1);
        sb.push_back(e);
      end
    end
    exp_addr = '0;
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (valid_out) begin
        pix_cnt++;
        if (sb.size() == 0) begin
          check("unexpected pixel", 32'(pixel_out), 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          check("pixel/sof/eol/eof", 32'({pixel_out, sof, eol, eof}),
                32'({e.pix, e.sof, e.eol, e.eof}));
          check("read issued for position", 32'(prev_rd_en), 32'(!e.pad));
        end
      end else begin
        check("markers without valid", 32'({sof, eol, eof}), 32'd0);
      end
      if (mem_rd_en) begin
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        exp_addr = exp_addr + 1'b1;
      end
      if (done) done_cnt++;
    end
    prev_rd_en = mem_rd_en;
  end

  task automatic run_frame(input scen_t s);
    int got = 0;
    int p0  = pix_cnt;
    int d0  = done_cnt;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= s.exp_k + 8; k++) begin
      hold  = (k > s.hold_after) && (k <= s.hold_after + s.hold_len);
      start = (k == s.restart_mid) || (s.restart_drain && k == NPOS + 1 + s.hold_len);
      @(negedge clk); #1;
      if (k == 1) check("busy after start", 32'(busy), 32'd1);
      if (done) begin
        got = k;
        break;
      end
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    start = 1'b0;
    check("done latency", 32'(got), 32'(s.exp_k));
    check("pixel count", 32'(pix_cnt - p0), 32'(NPOS));
    check("done count", 32'(done_cnt - d0), 32'd1);
    check("scoreboard empty", 32'(sb.size()), 32'd0);
    check("busy with done", 32'(busy), 32'd0);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      check("idle outputs", 32'({valid_out, busy, mem_rd_en, done}), 32'd0);
    end
  endtask

  initial begin
    int p0;
    int d0;
    tbl[0] = '{hold_after: 1, hold_len: 0, restart_mid: 0, restart_drain: 1'b0, exp_k: NPOS + 2};
    tbl[1] = '{hold_after: 5, hold_len: 3, restart_mid: 0, restart_drain: 1'b0, exp_k: NPOS + 5};
    tbl[2] = '{hold_after: 1, hold_len: 0, restart_mid: 4, restart_drain: 1'b1, exp_k: NPOS + 2};
    tbl[3] = '{hold_after: 2, hold_len: 1, restart_mid: 7, restart_drain: 1'b1, exp_k: NPOS + 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'({valid_out, sof, eol, eof, busy, done, mem_rd_en, pixel_out}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    idle_check(2);

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i]);
      idle_check(4);
    end

    // Reset in the middle of a frame.
    p0 = pix_cnt;
    d0 = done_cnt;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (pix_cnt - p0 >= 6) break;
    end
    check("pixels before reset", 32'(pix_cnt - p0), 32'd6);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post-reset valid/busy/done", 32'({valid_out, busy, done}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    idle_check(3);
    check("no done after reset", 32'(done_cnt - d0), 32'd0);
    run_frame(tbl[0]);
    idle_check(3);

    // Back-to-back frames: second start lands in the cycle after done.
    run_frame(tbl[0]);
    run_frame(tbl[0]);
    idle_check(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
